sap_datapath: RTL and testbench
===============================

# sap_datapath

SAP-1 datapath that responds to the control word from the instruction sequencer. It holds the program counter, MAR, 16×8 RAM, instruction register, accumulator A, register B, adder/subtractor with flags, and output register, all joined by a shared 8-bit W-bus. It returns the opcode nibble to the sequencer and exposes a RAM programming port for loading programs before run.

## Interface
- Parameters: none. All widths are fixed by the SAP-1 architecture.
- clock  in  1  system clock; every register updates on the rising edge.
- clear  in  1  asynchronous, active-low reset.
- cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt  in  1 each  control word from the sequencer; it changes on the falling edge.
- prog_we  in  1  RAM write strobe for the programming port.
- prog_addr  in  4  RAM write address.
- prog_data  in  8  RAM write data.
- instruction  out  4  IR[7:4], wired to the sequencer.
- out_port  out  8  output register.
- w_bus  out  8  current bus value, for debug.
- pc_value  out  4  program counter, for debug.
- carry  out  1  carry flag.
- zero  out  1  zero flag.
- halted  out  1  sticky halt indicator.
- bus_err  out  1  sticky bus-contention flag.

## Operation
- **W-bus drivers** (combinational):
  - ep drives {4'h0, PC}.
  - ce drives RAM[MAR].
  - ei drives {4'h0, IR[3:0]}.
  - ea drives A.
  - eu drives the ALU result.
  - With no driver enabled, the bus is 8'h00.
  - With more than one driver enabled, the bus is the bitwise OR of the enabled sources, and bus_err is set at the next rising edge and held until clear.
- **Loads** at the rising edge, using that cycle's bus value:
  - lm: MAR ← bus[3:0].
  - li: IR ← bus.
  - la: A ← bus.
  - lb: B ← bus.
  - lo: out_port ← bus.
- **PC**: cp increments PC modulo 16, so 4'hF wraps to 4'h0. Combining ep and cp in one cycle drives the old PC on the bus, then increments.
- **ALU**:
  - su=0: result = (A + B) mod 256.
  - su=1: result = (A + ~B + 1) mod 256.
  - Carry out is the 9th bit in both cases, so for SUB carry=1 means no borrow (A ≥ B).
  - Flags update only on a rising edge where la and eu are both 1: carry ← carry out, zero ← (result == 0). Otherwise the flags hold.
- **Self-referencing loads**:
  - la with ea: A reloads its own value.
  - la with eu: A takes the result computed from the pre-edge A.
- **Halt**:
  - At a rising edge with hlt=1, halted is set (sticky until clear).
  - While hlt=1 or halted=1, all loads, PC increments, and flag updates are inhibited.
  - Bus drivers still operate for observation.
- **RAM**:
  - prog_we writes RAM[prog_addr] ← prog_data at the rising edge, independent of halt.
  - A same-edge read via ce at the same address sees the old contents on the bus.
  - RAM is not cleared by reset.
- **Reset** (clear=0), asynchronous, with clear dominating all other inputs:
  - PC, MAR, IR, A, B, out_port are 0.
  - carry, zero, halted, bus_err are 0.
  - As a result, instruction=4'h0 and pc_value=0.

## Timing
- Control inputs are stable around the rising edge because the sequencer drives them on the falling edge.
- Bus to register load: 1 rising edge.
- A six-step instruction (T1–T6) completes in 6 clocks:
  - T1: ep+lm
  - T2: cp
  - T3: ce+li
  - T4: lm+ei, or ea+lo for OUT
  - T5: ce+la, or ce+lb
  - T6: la+eu(+su)
- After T3, instruction is valid for T4–T6 of the same instruction.
- After T4 (OUT), out_port is valid 1 clock later.
- clear deasserting between edges: the first load happens at the next rising edge.
- clear asserting mid-instruction aborts immediately; RAM is kept.

## Test plan
- **Reset mid-run:** run the program, pulse clear low between edges → all registers/flags 0 immediately, RAM intact, restart re-executes from PC=0.
- **Program run:**
  - RAM[0..4] = 09,1A,2B,E0,F0; RAM[9]=10, RAM[A]=14, RAM[B]=18.
  - Sequence the control word per T1–T6.
  - Expect out_port=0x0C after OUT, carry=1, zero=0, then halted=1 with A frozen at 0x0C despite la pulses.
- **Add overflow:** A=0xF0, B=0x20, la+eu → A=0x10, carry=1, zero=0.
- **Subtract to zero:** A=B=0x33, la+eu+su → A=0x00, zero=1, carry=1. Then A=0x01, B=0x02 → A=0xFF, carry=0.
- **Contention:** PC=5, RAM[MAR]=0x80, assert ep+ce → w_bus=0x85, bus_err=1 after the edge and still 1 after 10 quiet cycles.
- **PC wrap:** 16 cp pulses from 0 → pc_value sequence 1..F then 0. With ep+cp in one cycle, w_bus shows the pre-increment value.

Source files
------------

// File: rtl/sap_datapath.sv
// SAP-1 datapath: PC, MAR, 16x8 RAM, IR, A, B, add/sub ALU with flags and an
// output register, joined by an 8-bit W-bus driven by the sequencer's control word.
module sap_datapath (
    input  logic       clock,
    input  logic       clear,
    input  logic       cp,
    input  logic       ep,
    input  logic       lm,
    input  logic       ce,
    input  logic       li,
    input  logic       ei,
    input  logic       la,
    input  logic       ea,
    input  logic       su,
    input  logic       eu,
    input  logic       lb,
    input  logic       lo,
    input  logic       hlt,
    input  logic       prog_we,
    input  logic [3:0] prog_addr,
    input  logic [7:0] prog_data,
    output logic [3:0] instruction,
    output logic [7:0] out_port,
    output logic [7:0] w_bus,
    output logic [3:0] pc_value,
    output logic       carry,
    output logic       zero,
    output logic       halted,
    output logic       bus_err
);

    logic [3:0] pc;
    logic [3:0] mar;
    logic [7:0] ir;
    logic [7:0] a_reg;
    logic [7:0] b_reg;
    logic [7:0] out_reg;
    logic       carry_reg;
    logic       zero_reg;
    logic       halt_reg;
    logic       err_reg;
    logic [7:0] ram [16];

    logic [8:0] alu_sum;
    logic [7:0] bus;
    logic [2:0] drivers;
    logic       run;

    // ALU: subtraction is A + ~B + 1, so bit 8 is carry (no-borrow for SUB)
    always_comb begin
        alu_sum = {1'b0, a_reg} + {1'b0, (su ? ~b_reg : b_reg)} + {8'b0, su};
    end

    // W-bus: OR of every enabled source; more than one enabled is contention
    always_comb begin
        bus = '0;
        if (ep) bus = bus | {4'h0, pc};
        if (ce) bus = bus | ram[mar];
        if (ei) bus = bus | {4'h0, ir[3:0]};
        if (ea) bus = bus | a_reg;
        if (eu) bus = bus | alu_sum[7:0];
        drivers = {2'b0, ep} + {2'b0, ce} + {2'b0, ei} + {2'b0, ea} + {2'b0, eu};
        run     = !hlt && !halt_reg;
    end

    // Programming port write; RAM contents survive clear
    always_ff @(posedge clock) begin
        if (prog_we) ram[prog_addr] <= prog_data;
    end

    // Architectural registers; halt (pending or sticky) freezes loads, PC and flags
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            pc        <= '0;
            mar       <= '0;
            ir        <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            out_reg   <= '0;
            carry_reg <= 1'b0;
            zero_reg  <= 1'b0;
            halt_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            if (hlt) halt_reg <= 1'b1;
            if (drivers > 3'd1) err_reg <= 1'b1;
            if (run) begin
                if (cp) pc    <= pc + 4'd1;
                if (lm) mar   <= bus[3:0];
                if (li) ir    <= bus;
                if (la) a_reg <= bus;
                if (lb) b_reg <= bus;
                if (lo) out_reg <= bus;
                if (la && eu) begin
                    carry_reg <= alu_sum[8];
                    zero_reg  <= (alu_sum[7:0] == 8'h00);
                end
            end
        end
    end

    assign instruction = ir[7:4];
    assign out_port    = out_reg;
    assign w_bus       = bus;
    assign pc_value    = pc;
    assign carry       = carry_reg;
    assign zero        = zero_reg;
    assign halted      = halt_reg;
    assign bus_err     = err_reg;

endmodule

// File: tb/tb_sap_datapath.sv
// Scoreboard bench for sap_datapath: stimulus pushes hand-computed expectations,
// a monitor pops and compares them 3ns after each clock edge.
module tb_sap_datapath;

    logic       clock;
    logic       clear;
    logic       cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt;
    logic       prog_we;
    logic [3:0] prog_addr;
    logic [7:0] prog_data;
    logic [3:0] instruction;
    logic [7:0] out_port;
    logic [7:0] w_bus;
    logic [3:0] pc_value;
    logic       carry, zero, halted, bus_err;

    // control word bit positions {cp,ep,lm,ce,li,ei,la,ea,su,eu,lb,lo,hlt}
    localparam logic [12:0] NOP = 13'h0000;
    localparam logic [12:0] CP  = 13'h1000;
    localparam logic [12:0] EP  = 13'h0800;
    localparam logic [12:0] LM  = 13'h0400;
    localparam logic [12:0] CE  = 13'h0200;
    localparam logic [12:0] LI  = 13'h0100;
    localparam logic [12:0] EI  = 13'h0080;
    localparam logic [12:0] LA  = 13'h0040;
    localparam logic [12:0] EA  = 13'h0020;
    localparam logic [12:0] SU  = 13'h0010;
    localparam logic [12:0] EU  = 13'h0008;
    localparam logic [12:0] LB  = 13'h0004;
    localparam logic [12:0] LO  = 13'h0002;
    localparam logic [12:0] HLT = 13'h0001;

    localparam int S_BUS = 0, S_OUT = 1, S_PC = 2, S_INS = 3;
    localparam int S_C = 4, S_Z = 5, S_HALT = 6, S_ERR = 7;

    typedef struct {
        string      name;
        int         sel;
        logic [7:0] val;
    } exp_t;

    exp_t q[$];
    int   tests  = 0;
    int   failed = 0;

    sap_datapath dut (
        .clock(clock), .clear(clear),
        .cp(cp), .ep(ep), .lm(lm), .ce(ce), .li(li), .ei(ei), .la(la), .ea(ea),
        .su(su), .eu(eu), .lb(lb), .lo(lo), .hlt(hlt),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .instruction(instruction), .out_port(out_port), .w_bus(w_bus),
        .pc_value(pc_value), .carry(carry), .zero(zero), .halted(halted),
        .bus_err(bus_err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic void expect_val(input string n, input int s, input logic [7:0] v);
        exp_t e;
        e.name = n;
        e.sel  = s;
        e.val  = v;
        q.push_back(e);
    endfunction

    function automatic logic [7:0] observe(input int s);
        case (s)
            S_BUS:   return w_bus;
            S_OUT:   return out_port;
            S_PC:    return {4'h0, pc_value};
            S_INS:   return {4'h0, instruction};
            S_C:     return {7'h0, carry};
            S_Z:     return {7'h0, zero};
            S_HALT:  return {7'h0, halted};
            default: return {7'h0, bus_err};
        endcase
    endfunction

    // monitor: drain pending expectations shortly after every clock edge
    initial begin
        exp_t       e;
        logic [7:0] act;
        forever begin
            @(clock);
            #3;
            while (q.size() > 0) begin
                e   = q.pop_front();
                act = observe(e.sel);
                tests++;
                if (act !== e.val) begin
                    failed++;
                    $display("FAIL %s: got %02h expected %02h", e.name, act, e.val);
                end
            end
        end
    end

    // sequencer model: control word changes just after the falling edge
    task automatic drive(input logic [12:0] cw);
        @(negedge clock);
        {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt} = cw;
        prog_we = 1'b0;
        #1;
    endtask

    task automatic edge_wait();
        @(posedge clock);
        #1;
    endtask

    task automatic tick(input logic [12:0] cw);
        drive(cw);
        edge_wait();
    endtask

    task automatic prog(input logic [3:0] addr, input logic [7:0] data);
        drive(NOP);
        prog_we   = 1'b1;
        prog_addr = addr;
        prog_data = data;
        edge_wait();
    endtask

    task automatic do_clear();
        @(negedge clock);
        {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt} = NOP;
        prog_we = 1'b0;
        #2 clear = 1'b0;
        #1;
        expect_val("clr_pc",    S_PC,   8'h00);
        expect_val("clr_ins",   S_INS,  8'h00);
        expect_val("clr_out",   S_OUT,  8'h00);
        expect_val("clr_carry", S_C,    8'h00);
        expect_val("clr_zero",  S_Z,    8'h00);
        expect_val("clr_halt",  S_HALT, 8'h00);
        expect_val("clr_err",   S_ERR,  8'h00);
        edge_wait();
        @(negedge clock);
        clear = 1'b1;
    endtask

    task automatic fetch(input logic [3:0] op);
        tick(EP | LM);
        tick(CP);
        tick(CE | LI);
        expect_val("opcode", S_INS, {4'h0, op});
    endtask

    // LDA 9, ADD A, SUB B, OUT, HLT; runs the first n instructions
    task automatic run_program(input int n);
        if (n >= 1) begin
            fetch(4'h0); tick(LM | EI); tick(CE | LA); tick(NOP);
        end
        if (n >= 2) begin
            fetch(4'h1); tick(LM | EI); tick(CE | LB); tick(LA | EU);
            expect_val("add_carry", S_C, 8'h00);
            expect_val("add_zero",  S_Z, 8'h00);
        end
        if (n >= 3) begin
            fetch(4'h2); tick(LM | EI); tick(CE | LB); tick(LA | EU | SU);
            expect_val("sub_carry", S_C, 8'h01);
            expect_val("sub_zero",  S_Z, 8'h00);
        end
        if (n >= 4) begin
            fetch(4'hE); tick(EA | LO);
            expect_val("out_port", S_OUT, 8'h0C);
            tick(NOP); tick(NOP);
        end
        if (n >= 5) begin
            fetch(4'hF);
            expect_val("pre_halt", S_HALT, 8'h00);
            tick(HLT);
            expect_val("halted", S_HALT, 8'h01);
            expect_val("run_err", S_ERR, 8'h00);
        end
    endtask

    // places a and b into A and B through RAM[0] (MAR is 0 after clear)
    task automatic load_ab(input logic [7:0] a, input logic [7:0] b);
        prog(4'h0, a);
        tick(CE | LA);
        prog(4'h0, b);
        tick(CE | LB);
    endtask

    task automatic check_a(input string n, input logic [7:0] v);
        drive(EA);
        expect_val(n, S_BUS, v);
        edge_wait();
    endtask

    initial begin
        clear = 1'b0;
        {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, hlt} = NOP;
        prog_we = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        #1;
        expect_val("rst_pc",    S_PC,   8'h00);
        expect_val("rst_ins",   S_INS,  8'h00);
        expect_val("rst_out",   S_OUT,  8'h00);
        expect_val("rst_flags", S_C,    8'h00);
        expect_val("rst_zero",  S_Z,    8'h00);
        expect_val("rst_halt",  S_HALT, 8'h00);
        expect_val("rst_err",   S_ERR,  8'h00);
        expect_val("rst_bus",   S_BUS,  8'h00);
        edge_wait();
        @(negedge clock);
        clear = 1'b1;

        prog(4'h0, 8'h09); prog(4'h1, 8'h1A); prog(4'h2, 8'h2B);
        prog(4'h3, 8'hE0); prog(4'h4, 8'hF0);
        prog(4'h9, 8'h10); prog(4'hA, 8'h14); prog(4'hB, 8'h18);

        // full program, then confirm halt freezes A, PC and flags
        run_program(5);
        tick(CE | LA);
        tick(CP);
        tick(LA | EU);
        expect_val("halt_pc",    S_PC, 8'h05);
        expect_val("halt_carry", S_C,  8'h01);
        check_a("halt_a", 8'h0C);

        // abort after OUT, then rerun from PC=0 with RAM intact
        do_clear();
        run_program(4);
        do_clear();
        run_program(5);
        do_clear();

        // add overflow
        load_ab(8'hF0, 8'h20);
        tick(LA | EU);
        expect_val("ovf_carry", S_C, 8'h01);
        expect_val("ovf_zero",  S_Z, 8'h00);
        check_a("ovf_a", 8'h10);

        // subtract to zero, then borrow
        load_ab(8'h33, 8'h33);
        tick(LA | EU | SU);
        expect_val("subz_zero",  S_Z, 8'h01);
        expect_val("subz_carry", S_C, 8'h01);
        check_a("subz_a", 8'h00);
        load_ab(8'h01, 8'h02);
        tick(LA | EU | SU);
        expect_val("borrow_carry", S_C, 8'h00);
        expect_val("borrow_zero",  S_Z, 8'h00);
        check_a("borrow_a", 8'hFF);
        // eu without la leaves flags alone (A+B = 0x01 here)
        tick(EU);
        expect_val("hold_carry", S_C, 8'h00);
        expect_val("hold_zero",  S_Z, 8'h00);

        // same-edge RAM write and ce read at address 0
        prog(4'h0, 8'h80);
        drive(CE);
        prog_we = 1'b1; prog_addr = 4'h0; prog_data = 8'h55;
        expect_val("ram_old", S_BUS, 8'h80);
        edge_wait();
        expect_val("ram_new", S_BUS, 8'h55);
        prog(4'h0, 8'h80);

        // contention: PC=5, RAM[MAR]=0x80
        repeat (5) tick(CP);
        expect_val("pc5", S_PC, 8'h05);
        drive(EP | CE);
        expect_val("cont_bus", S_BUS, 8'h85);
        expect_val("cont_err_pre", S_ERR, 8'h00);
        edge_wait();
        expect_val("cont_err", S_ERR, 8'h01);
        repeat (10) tick(NOP);
        expect_val("cont_sticky", S_ERR, 8'h01);

        // PC wrap
        do_clear();
        for (int i = 1; i <= 16; i++) begin
            tick(CP);
            expect_val("pc_wrap", S_PC, 8'(i % 16));
        end
        repeat (3) tick(CP);
        drive(EP | CP);
        expect_val("epcp_bus", S_BUS, 8'h03);
        edge_wait();
        expect_val("epcp_pc", S_PC, 8'h04);
        expect_val("epcp_err", S_ERR, 8'h00);

        // bounded drain of the scoreboard
        for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clock);
        #4;
        if (q.size() > 0) begin
            failed++;
            tests++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
